// File: rtl/kalman_pkg.sv
// Shared constants and types for the Kalman filter ALU steps.
// Data is signed two's complement; gains are unsigned Q0.GAIN_W fractions.
package kalman_pkg;

    localparam int DATA_W    = 23;
    localparam int GAIN_W    = 13;
    localparam int FRAC_BITS = GAIN_W;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic        [GAIN_W-1:0] gain_t;

endpackage

// File: rtl/kalman_mac.sv
// Combinational multiply-shift-accumulate: acc +/- floor(gain * mult / 2^FRAC_BITS),
// saturated to the signed DATA_W range.
module kalman_mac
    import kalman_pkg::*;
(
    input  logic        [GAIN_W-1:0] gain,
    input  logic signed [DATA_W-1:0] mult,
    input  logic signed [DATA_W-1:0] acc,
    input  logic                     sub,
    output logic signed [DATA_W-1:0] result
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;

    logic signed [GAIN_W:0]   gain_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W:0]   term;
    logic signed [DATA_W:0]   acc_ext;
    logic signed [DATA_W:0]   sum;

    // Dropping the low FRAC_BITS of a two's complement product is a floor shift.
    always_comb begin
        gain_s  = $signed({1'b0, gain});
        prod    = gain_s * mult;
        term    = prod[FRAC_BITS +: DATA_W+1];
        acc_ext = {acc[DATA_W-1], acc};
        sum     = sub ? (acc_ext - term) : (acc_ext + term);
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            result = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            result = sum[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/kalman_alu6.sv
// Kalman step 6: state correction and covariance update, one product per cycle
// through a shared saturating MAC, with a start/busy/done handshake.
module kalman_alu6
    import kalman_pkg::*;
(
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic        [GAIN_W-1:0] K0_in,
    input  logic        [GAIN_W-1:0] K1_in,
    input  logic signed [DATA_W-1:0] y_in,
    input  logic signed [DATA_W-1:0] angle_in,
    input  logic signed [DATA_W-1:0] bias_in,
    input  logic signed [DATA_W-1:0] P00_in,
    input  logic signed [DATA_W-1:0] P01_in,
    input  logic signed [DATA_W-1:0] P10_in,
    input  logic signed [DATA_W-1:0] P11_in,
    output logic signed [DATA_W-1:0] angle_out,
    output logic signed [DATA_W-1:0] bias_out,
    output logic signed [DATA_W-1:0] P00_out,
    output logic signed [DATA_W-1:0] P01_out,
    output logic signed [DATA_W-1:0] P10_out,
    output logic signed [DATA_W-1:0] P11_out,
    output logic                     busy,
    output logic                     done
);

    localparam logic [2:0] LAST_STEP = 3'd5;

    state_t state, state_next;
    logic [2:0] step;
    gain_t k0_q, k1_q;
    data_t y_q, angle_q, bias_q, p00_q, p01_q, p10_q, p11_q;

    gain_t mac_gain;
    data_t mac_mult, mac_acc, mac_result;
    logic  mac_sub;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                busy = 1'b1;
                if (step == LAST_STEP) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured once per run; results never feed back into them,
    // which is what lets steps 4 and 5 see the pre-update P00/P01.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            step    <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            y_q     <= '0;
            angle_q <= '0;
            bias_q  <= '0;
            p00_q   <= '0;
            p01_q   <= '0;
            p10_q   <= '0;
            p11_q   <= '0;
        end else if (state == IDLE && start) begin
            step    <= '0;
            k0_q    <= K0_in;
            k1_q    <= K1_in;
            y_q     <= y_in;
            angle_q <= angle_in;
            bias_q  <= bias_in;
            p00_q   <= P00_in;
            p01_q   <= P01_in;
            p10_q   <= P10_in;
            p11_q   <= P11_in;
        end else if (state == CALC) begin
            step <= step + 3'd1;
        end
    end

    always_comb begin
        mac_gain = k0_q;
        mac_mult = y_q;
        mac_acc  = angle_q;
        mac_sub  = 1'b0;
        case (step)
            3'd1: begin mac_gain = k1_q; mac_mult = y_q;   mac_acc = bias_q; mac_sub = 1'b0; end
            3'd2: begin mac_gain = k0_q; mac_mult = p00_q; mac_acc = p00_q;  mac_sub = 1'b1; end
            3'd3: begin mac_gain = k0_q; mac_mult = p01_q; mac_acc = p01_q;  mac_sub = 1'b1; end
            3'd4: begin mac_gain = k1_q; mac_mult = p00_q; mac_acc = p10_q;  mac_sub = 1'b1; end
            3'd5: begin mac_gain = k1_q; mac_mult = p01_q; mac_acc = p11_q;  mac_sub = 1'b1; end
            default: ;
        endcase
    end

    kalman_mac u_mac (
        .gain   (mac_gain),
        .mult   (mac_mult),
        .acc    (mac_acc),
        .sub    (mac_sub),
        .result (mac_result)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            angle_out <= '0;
            bias_out  <= '0;
            P00_out   <= '0;
            P01_out   <= '0;
            P10_out   <= '0;
            P11_out   <= '0;
        end else if (state == CALC) begin
            case (step)
                3'd0: angle_out <= mac_result;
                3'd1: bias_out  <= mac_result;
                3'd2: P00_out   <= mac_result;
                3'd3: P01_out   <= mac_result;
                3'd4: P10_out   <= mac_result;
                3'd5: P11_out   <= mac_result;
                default: ;
            endcase
        end
    end

endmodule
